// File: rtl/c3lib_rst_seq_pkg.sv
// Shared types and dly_cfg field helpers for the c3lib reset sequencer.
package c3lib_rst_seq_pkg;

  localparam int unsigned NUM_DOM_DEF = 4;
  localparam int unsigned CNT_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_ASSERTED  = 2'd0,
    ST_RELEASING = 2'd1,
    ST_RELEASED  = 2'd2,
    ST_ASSERTING = 2'd3
  } seq_state_e;

  // LSB position of the delay field for a given stage inside dly_cfg.
  function automatic int unsigned dly_lsb(input int unsigned stage, input int unsigned cnt_w);
    return stage * cnt_w;
  endfunction

endpackage

// File: rtl/c3lib_rst_seq_cnt.sv
// Loadable down-counter that times one sequencer stage; holds at zero.
module c3lib_rst_seq_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/c3lib_rst_seq_ctrl.sv
// Reset sequencer: releases active-low domain resets in ascending order and
// re-asserts them in descending order, with a programmable delay per stage.
module c3lib_rst_seq_ctrl
  import c3lib_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOM = NUM_DOM_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned STG_W   = $clog2(NUM_DOM)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     seq_en,
  input  logic [NUM_DOM*CNT_W-1:0] dly_cfg,
  output logic [NUM_DOM-1:0]       dom_rst_n,
  output logic                     seq_busy,
  output logic                     seq_done,
  output logic [STG_W-1:0]         cur_stage
);

  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_DOM - 1);

  seq_state_e         state, state_nxt;
  logic [STG_W-1:0]   stage, stage_nxt;
  logic [NUM_DOM-1:0] dom_nxt;
  logic               busy_nxt, done_nxt;
  logic               cnt_load;
  logic [STG_W-1:0]   load_stage;
  logic [CNT_W-1:0]   load_val;
  logic               cnt_zero;
  logic [CNT_W-1:0]   dly_arr [NUM_DOM];

  for (genvar i = 0; i < int'(NUM_DOM); i++) begin : g_dly
    assign dly_arr[i] = dly_cfg[dly_lsb(i, CNT_W) +: CNT_W];
  end

  assign load_val = dly_arr[load_stage];

  c3lib_rst_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (load_val),
    .zero_c   (cnt_zero)
  );

  // Next-state logic; a direction reversal takes priority over a stage action.
  always_comb begin
    state_nxt  = state;
    stage_nxt  = stage;
    dom_nxt    = dom_rst_n;
    cnt_load   = 1'b0;
    load_stage = stage;

    unique case (state)
      ST_ASSERTED: begin
        if (seq_en) begin
          state_nxt  = ST_RELEASING;
          stage_nxt  = '0;
          cnt_load   = 1'b1;
          load_stage = '0;
        end
      end

      ST_RELEASING: begin
        if (!seq_en) begin
          // Domains 0..stage-1 are out of reset; back off from the highest one.
          if (stage == '0) begin
            state_nxt = ST_ASSERTED;
          end else begin
            state_nxt  = ST_ASSERTING;
            stage_nxt  = stage - STG_W'(1);
            cnt_load   = 1'b1;
            load_stage = stage - STG_W'(1);
          end
        end else if (cnt_zero) begin
          dom_nxt[stage] = 1'b1;
          if (stage == LAST_STG) begin
            state_nxt = ST_RELEASED;
          end else begin
            stage_nxt  = stage + STG_W'(1);
            cnt_load   = 1'b1;
            load_stage = stage + STG_W'(1);
          end
        end
      end

      ST_RELEASED: begin
        if (!seq_en) begin
          state_nxt  = ST_ASSERTING;
          stage_nxt  = LAST_STG;
          cnt_load   = 1'b1;
          load_stage = LAST_STG;
        end
      end

      ST_ASSERTING: begin
        if (seq_en) begin
          // Domains stage+1.. are in reset; resume releasing from the lowest one.
          if (stage == LAST_STG) begin
            state_nxt = ST_RELEASED;
          end else begin
            state_nxt  = ST_RELEASING;
            stage_nxt  = stage + STG_W'(1);
            cnt_load   = 1'b1;
            load_stage = stage + STG_W'(1);
          end
        end else if (cnt_zero) begin
          dom_nxt[stage] = 1'b0;
          if (stage == '0) begin
            state_nxt = ST_ASSERTED;
          end else begin
            stage_nxt  = stage - STG_W'(1);
            cnt_load   = 1'b1;
            load_stage = stage - STG_W'(1);
          end
        end
      end

      default: begin
        state_nxt = ST_ASSERTED;
        stage_nxt = '0;
        dom_nxt   = '0;
      end
    endcase

    busy_nxt = (state_nxt == ST_RELEASING) || (state_nxt == ST_ASSERTING);
    done_nxt = (state_nxt == ST_RELEASED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ASSERTED;
      stage     <= '0;
      dom_rst_n <= '0;
      seq_busy  <= 1'b0;
      seq_done  <= 1'b0;
    end else begin
      state     <= state_nxt;
      stage     <= stage_nxt;
      dom_rst_n <= dom_nxt;
      seq_busy  <= busy_nxt;
      seq_done  <= done_nxt;
    end
  end

  assign cur_stage = stage;

endmodule

// File: tb/tb_c3lib_rst_seq_ctrl.sv
// Directed + randomized bench for c3lib_rst_seq_ctrl (NUM_DOM=4, CNT_W=8).
module tb_c3lib_rst_seq_ctrl;

  localparam int unsigned NUM_DOM = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned STG_W   = 2;

  logic                     clk;
  logic                     rst;
  logic                     seq_en;
  logic [NUM_DOM*CNT_W-1:0] dly_cfg;
  logic [NUM_DOM-1:0]       dom_rst_n;
  logic                     seq_busy;
  logic                     seq_done;
  logic [STG_W-1:0]         cur_stage;

  c3lib_rst_seq_ctrl #(
    .NUM_DOM (NUM_DOM),
    .CNT_W   (CNT_W),
    .STG_W   (STG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .seq_en    (seq_en),
    .dly_cfg   (dly_cfg),
    .dom_rst_n (dom_rst_n),
    .seq_busy  (seq_busy),
    .seq_done  (seq_done),
    .cur_stage (cur_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] dom;
    logic       busy;
    logic       done;
    logic [1:0] stage;
  } exp_t;

  exp_t sb[$];
  int   dly[4];
  int   n_pass = 0;
  int   n_chk  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic apply_dly();
    dly_cfg = {8'(dly[3]), 8'(dly[2]), 8'(dly[1]), 8'(dly[0])};
  endtask

  function automatic logic [3:0] therm(input int n);
    logic [4:0] one;
    one = 5'd1;
    return 4'((one << n) - 5'd1);
  endfunction

  // Number of domains released e edges after the edge that sampled seq_en=1.
  function automatic int rel_count(input int e);
    int t;
    int n;
    t = 0;
    n = 0;
    for (int k = 0; k < 4; k++) begin
      t += dly[k] + 1;
      if (t <= e) n++;
    end
    return n;
  endfunction

  // Number of domains still released e edges after seq_en=0 sampled in RELEASED.
  function automatic int asr_count(input int e);
    int t;
    int n;
    t = 0;
    n = 4;
    for (int k = 3; k >= 0; k--) begin
      t += dly[k] + 1;
      if (t <= e) n--;
    end
    return n;
  endfunction

  task automatic push(input string tag, input int n, input logic busy, input logic done,
                      input int stage);
    exp_t x;
    x.tag   = tag;
    x.dom   = therm(n);
    x.busy  = busy;
    x.done  = done;
    x.stage = 2'(stage);
    sb.push_back(x);
  endtask

  task automatic push_release(input string tag, input int e_first, input int e_last);
    int n;
    int tot;
    tot = rel_count(1000) == 4 ? (dly[0] + dly[1] + dly[2] + dly[3] + 4) : 1000;
    for (int e = e_first; e <= e_last; e++) begin
      n = rel_count(e);
      push($sformatf("%s@%0d", tag, e), n, e < tot, e >= tot, (n > 3) ? 3 : n);
    end
  endtask

  task automatic run_sb();
    exp_t x;
    while (sb.size() != 0) begin
      tick();
      x = sb.pop_front();
      chk({x.tag, ".dom"},   32'(dom_rst_n), 32'(x.dom));
      chk({x.tag, ".busy"},  32'(seq_busy),  32'(x.busy));
      chk({x.tag, ".done"},  32'(seq_done),  32'(x.done));
      chk({x.tag, ".stage"}, 32'(cur_stage), 32'(x.stage));
    end
  endtask

  initial begin
    logic [3:0] prev;
    logic [4:0] inc;
    int         n;

    rst     = 1'b1;
    seq_en  = 1'b1;
    dly     = '{0, 1, 2, 3};
    apply_dly();

    // Reset held for 3 edges with seq_en=1
    for (int i = 0; i < 3; i++) push($sformatf("rst%0d", i), 0, 1'b0, 1'b0, 0);
    run_sb();

    // Release timing: edge 0 is the first edge with rst low
    rst = 1'b0;
    push_release("rel", 0, 12);
    run_sb();

    // Assert timing from RELEASED
    seq_en = 1'b0;
    for (int e = 0; e <= 12; e++) begin
      n = asr_count(e);
      push($sformatf("asr@%0d", e), n, e < 10, 1'b0, (n == 0) ? 0 : n - 1);
    end
    run_sb();

    // Reversal: all delays 5, drop seq_en two edges after bit1 rises (edge 12)
    dly = '{5, 5, 5, 5};
    apply_dly();
    seq_en = 1'b1;
    push_release("rev_up", 0, 13);
    run_sb();
    seq_en = 1'b0;
    for (int j = 0; j <= 13; j++) begin
      n = (j < 6) ? 2 : ((j < 12) ? 1 : 0);
      push($sformatf("rev_dn@%0d", j), n, j < 12, 1'b0, (n == 0) ? 0 : n - 1);
    end
    run_sb();

    // Mid-sequence reset at dom_rst_n=0111, then restart from stage 0
    dly = '{1, 1, 1, 1};
    apply_dly();
    seq_en = 1'b1;
    push_release("mid", 0, 6);
    run_sb();
    rst = 1'b1;
    push("mid_rst", 0, 1'b0, 1'b0, 0);
    run_sb();
    rst = 1'b0;
    push_release("restart", 0, 4);
    run_sb();

    // Randomized sweep of seq_en and dly_cfg checking structural invariants
    prev = dom_rst_n;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 5) == 0) seq_en = ~seq_en;
      if ($urandom_range(0, 15) == 0) begin
        for (int k = 0; k < 4; k++) dly[k] = int'($urandom_range(0, 3));
        apply_dly();
      end
      tick();
      inc = {1'b0, dom_rst_n} + 5'd1;
      chk("sweep.therm", 32'(dom_rst_n & inc[3:0]), 32'd0);
      chk("sweep.onebit", 32'($onehot0(dom_rst_n ^ prev)), 32'd1);
      chk("sweep.busy_done", 32'(seq_busy & seq_done), 32'd0);
      prev = dom_rst_n;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
